// File: rtl/ram_loader.sv
// Byte-pair to 16-bit word loader feeding a 512-word RAM.
// Optional pre-clear pass of the RAM enabled by RAM_LOADER_CLEAR_EN.
module ram_loader #(
  parameter int LAST_ADDR = 511
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [8:0]  ram_address,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic        busy,
  output logic        done,
  output logic [9:0]  word_count
);

  localparam logic [8:0] LAST = 9'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE,
`ifdef RAM_LOADER_CLEAR_EN
    CLEAR,
`endif
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]  hi_q, hi_n;
  logic [8:0]  addr_n;
  logic [15:0] in_n;
  logic        load_n;
  logic        busy_n;
  logic        done_n;
  logic [9:0]  cnt_n;
  logic        at_last;

  assign at_last = (ram_address == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hi_q        <= '0;
      ram_address <= '0;
      ram_in      <= '0;
      ram_load    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      word_count  <= '0;
    end else begin
      state       <= state_n;
      hi_q        <= hi_n;
      ram_address <= addr_n;
      ram_in      <= in_n;
      ram_load    <= load_n;
      busy        <= busy_n;
      done        <= done_n;
      word_count  <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef RAM_LOADER_CLEAR_EN
          state_n = CLEAR;
`else
          state_n = WAIT_HI;
`endif
        end
      end
`ifdef RAM_LOADER_CLEAR_EN
      CLEAR: begin
        if (at_last) state_n = WAIT_HI;
      end
`endif
      WAIT_HI: begin
        if (rx_valid) state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (rx_valid) state_n = at_last ? DONE : WAIT_HI;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    addr_n = ram_address;
    in_n   = ram_in;
    load_n = 1'b0;
    busy_n = busy;
    done_n = done;
    cnt_n  = word_count;
    hi_n   = hi_q;

    // a data write retires on the edge that ends its strobe
    if (ram_load
`ifdef RAM_LOADER_CLEAR_EN
        && state != CLEAR
`endif
       ) begin
      if (!at_last) addr_n = ram_address + 9'd1;
      cnt_n = word_count + 10'd1;
    end

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          addr_n = '0;
          cnt_n  = '0;
          done_n = 1'b0;
          busy_n = 1'b1;
`ifdef RAM_LOADER_CLEAR_EN
          in_n   = '0;
          load_n = 1'b1;
`endif
        end
      end
`ifdef RAM_LOADER_CLEAR_EN
      CLEAR: begin
        in_n   = '0;
        load_n = !at_last;
        addr_n = at_last ? 9'd0 : ram_address + 9'd1;
        cnt_n  = '0;
      end
`endif
      WAIT_HI: begin
        if (rx_valid) hi_n = rx_data;
      end
      WAIT_LO: begin
        if (rx_valid) begin
          in_n   = {hi_q, rx_data};
          load_n = 1'b1;
          if (at_last) begin
            busy_n = 1'b0;
            done_n = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
